led_band_decoder: RTL



---
 rtl/led_band_decoder_pkg.sv | 22 ++
 rtl/led_band_decoder_if.sv | 44 ++++
 rtl/led_band_decoder_check.sv | 40 ++++
 rtl/led_band_decoder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/led_band_decoder_pkg.sv
// led_pkg: shared definitions for the LED band decoder.
//   LED_W    - LED vector width (only 16 is supported)
//   MAX_RUN  - largest legal band length
//   state_e  - decoder FSM states
//   rotl1    - one-step circular left rotation of an LED vector
// Optional feature macro used elsewhere in this slice: LED_DECODE_REV_EN.
package led_pkg;

  localparam int LED_W   = 16;
  localparam int MAX_RUN = 8;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    LOCK = 2'd1,
    ERR  = 2'd2
  } state_e;

  function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

endpackage

// File: rtl/led_band_decoder_if.sv
// led_band_decoder_if: groups the sample stream and status outputs of the
// LED band decoder.
//   master modport (sample source / monitor side): drives led_in, led_vld,
//     resync; observes locked, err, run_len, switch_out, tail_pos,
//     step_cnt, state (FSM debug) and, with LED_DECODE_REV_EN, rev_cnt.
//   slave modport (decoder side): the mirror image.
// Handshake: a sample is consumed on every rising clk edge where led_vld=1
// and resync=0; there is no back-pressure, the decoder always accepts.
interface led_band_decoder_if #(
  parameter int CNT_W = 16
);
  import led_pkg::*;

  logic [LED_W-1:0] led_in;
  logic             led_vld;
  logic             resync;
  logic             locked;
  logic             err;
  logic [3:0]       run_len;
  logic [2:0]       switch_out;
  logic [3:0]       tail_pos;
  logic [CNT_W-1:0] step_cnt;
  state_e           state;
`ifdef LED_DECODE_REV_EN
  logic [7:0]       rev_cnt;
`endif

  modport master (
    output led_in, led_vld, resync,
    input  locked, err, run_len, switch_out, tail_pos, step_cnt, state
`ifdef LED_DECODE_REV_EN
    , input rev_cnt
`endif
  );

  modport slave (
    input  led_in, led_vld, resync,
    output locked, err, run_len, switch_out, tail_pos, step_cnt, state
`ifdef LED_DECODE_REV_EN
    , output rev_cnt
`endif
  );

endinterface

// File: rtl/led_band_decoder_check.sv
// led_band_check: combinational test for one contiguous circular band.
//   vec_i       - LED vector under test
//   valid_o     - 1 when vec_i holds a single circular run of 1..MAX_RUN ones
//   popcount_o  - number of ones (low 4 bits; only meaningful when valid_o)
//   tail_o      - index of the run's lowest bit (only meaningful when valid_o)
module led_band_check
  import led_pkg::*;
#(
  parameter int MAX_RUN_P = MAX_RUN
) (
  input  logic [LED_W-1:0] vec_i,
  output logic             valid_o,
  output logic [3:0]       popcount_o,
  output logic [3:0]       tail_o
);

  logic [4:0] pop;
  logic [4:0] starts;
  logic [3:0] tail;

  // A "start" is a 1 whose circular lower neighbour is 0. Exactly one start
  // means one band; all-ones has no start, split bands have several.
  always_comb begin
    pop    = '0;
    starts = '0;
    tail   = '0;
    for (int i = 0; i < LED_W; i++) begin
      pop = pop + 5'(vec_i[i]);
      if (vec_i[i] && !vec_i[(i + LED_W - 1) % LED_W]) begin
        starts = starts + 5'd1;
        tail   = 4'(i);
      end
    end
  end

  assign valid_o    = (pop != 5'd0) && (pop <= 5'(MAX_RUN_P)) && (starts == 5'd1);
  assign popcount_o = pop[3:0];
  assign tail_o     = tail;

endmodule

// File: rtl/led_band_decoder.sv
// led_band_decoder: locks onto the rotating LED band of the snake generator,
// recovers run length / switch value and tracks position and step count,
// flagging any illegal transition with a sticky err.
//   clk, rst_n   - clock and synchronous active-low reset
//   bus (slave)  - led_in/led_vld/resync in; locked, err, run_len,
//                  switch_out, tail_pos, step_cnt, state (debug) out
// Optional: LED_DECODE_REV_EN adds bus.rev_cnt, counting 15->0 tail wraps.
module led_band_decoder
  import led_pkg::*;
#(
  parameter int LED_W_P = LED_W,
  parameter int MAX_RUN_P = MAX_RUN,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_band_decoder_if.slave    bus
);

  state_e             state_q, state_d;
  logic [LED_W_P-1:0] prev_q, prev_d;
  logic [3:0]         run_q, run_d;
  logic [3:0]         tail_q, tail_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               err_q, err_d;
`ifdef LED_DECODE_REV_EN
  logic [7:0]         rev_q, rev_d;
`endif

  logic       chk_valid;
  logic [3:0] chk_pop;
  logic [3:0] chk_tail;

  led_band_check #(
    .MAX_RUN_P (MAX_RUN_P)
  ) u_check (
    .vec_i      (bus.led_in),
    .valid_o    (chk_valid),
    .popcount_o (chk_pop),
    .tail_o     (chk_tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACQ;
      prev_q  <= '0;
      run_q   <= '0;
      tail_q  <= '0;
      step_q  <= '0;
      err_q   <= 1'b0;
`ifdef LED_DECODE_REV_EN
      rev_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      tail_q  <= tail_d;
      step_q  <= step_d;
      err_q   <= err_d;
`ifdef LED_DECODE_REV_EN
      rev_q   <= rev_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    tail_d  = tail_q;
    step_d  = step_q;
    err_d   = err_q;
`ifdef LED_DECODE_REV_EN
    rev_d   = rev_q;
`endif
    if (bus.resync) begin
      // Same clearing as reset; a coincident sample is dropped.
      state_d = ACQ;
      prev_d  = '0;
      run_d   = '0;
      tail_d  = '0;
      step_d  = '0;
      err_d   = 1'b0;
`ifdef LED_DECODE_REV_EN
      rev_d   = '0;
`endif
    end else if (bus.led_vld) begin
      unique case (state_q)
        ACQ: begin
          if (chk_valid) begin
            state_d = LOCK;
            prev_d  = bus.led_in;
            run_d   = chk_pop;
            tail_d  = chk_tail;
            step_d  = '0;
`ifdef LED_DECODE_REV_EN
            rev_d   = '0;
`endif
          end
        end
        LOCK: begin
          if (bus.led_in == prev_q) begin
            // repeated sample: generator has not stepped yet
          end else if (bus.led_in == rotl1(prev_q)) begin
            prev_d = bus.led_in;
            tail_d = tail_q + 4'd1;
            step_d = (step_q == '1) ? step_q : step_q + CNT_W'(1);
`ifdef LED_DECODE_REV_EN
            if (tail_q == 4'd15) rev_d = rev_q + 8'd1;
`endif
          end else begin
            // tail_pos/step_cnt keep their last values for post-mortem
            state_d = ERR;
            err_d   = 1'b1;
            run_d   = '0;
          end
        end
        default: begin
          // ERR: wait for resync or reset
        end
      endcase
    end
  end

  assign bus.locked     = (state_q == LOCK);
  assign bus.err        = err_q;
  assign bus.run_len    = run_q;
  // run_q is non-zero only while locked, so the subtraction never underflows there
  assign bus.switch_out = (state_q == LOCK) ? 3'(run_q - 4'd1) : 3'd0;
  assign bus.tail_pos   = tail_q;
  assign bus.step_cnt   = step_q;
  assign bus.state      = state_q;
`ifdef LED_DECODE_REV_EN
  assign bus.rev_cnt    = rev_q;
`endif

endmodule
